// File: rtl/pipelined_ram_block.sv
// pipelined_ram_block
// Single-clock simple-dual-port RAM used as sample/coefficient storage.
// The input sample loader drives the write side. The convolution datapath
// reads from the read side.
//
// Features:
//   - per-lane byte enables
//   - configurable read latency (1..4) with a read-valid pulse
//   - selectable read-during-write policy
//   - post-reset clear engine that writes INIT_VALUE to every location
//
// Optional feature: define RAM_PARITY_EN to store one even-parity bit per lane.
// The parity is checked on the data leaving the read pipeline.
//
// Ports:
//   clk               rising-edge clock
//   rst               synchronous active-high reset
//   busy_o            high while in reset or while clearing; accesses are ignored
//   write_en_i        write strobe
//   write_addr_i      write address
//   write_be_i        lane enables, bit k covers [k*LANE_WIDTH +: LANE_WIDTH]
//   write_data_i      write data
//   read_en_i         read request
//   read_addr_i       read address
//   read_data_o       registered read data, holds between valid pulses
//   read_valid_o      one-cycle pulse READ_LATENCY cycles after an accepted read
//   read_parity_err_o lane parity mismatch, qualified by read_valid_o

module pipelined_ram_block #(
   parameter int                    DATA_WIDTH     = 8,
   parameter int                    ADDR_WIDTH     = 5,
   parameter int                    LANE_WIDTH     = 8,
   parameter int                    READ_LATENCY   = 1,
   parameter int                    RDW_MODE       = 0,
   parameter int                    CLEAR_ON_RESET = 1,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE     = '0
) (
   input  logic                                clk,
   input  logic                                rst,
   output logic                                busy_o,
   input  logic                                write_en_i,
   input  logic [ADDR_WIDTH-1:0]               write_addr_i,
   input  logic [DATA_WIDTH/LANE_WIDTH-1:0]    write_be_i,
   input  logic [DATA_WIDTH-1:0]               write_data_i,
   input  logic                                read_en_i,
   input  logic [ADDR_WIDTH-1:0]               read_addr_i,
   output logic [DATA_WIDTH-1:0]               read_data_o,
   output logic                                read_valid_o,
   output logic                                read_parity_err_o
);

   localparam int NUM_LANES = DATA_WIDTH / LANE_WIDTH;
   localparam int DEPTH     = 2 ** ADDR_WIDTH;
`ifdef RAM_PARITY_EN
   localparam int PAR_W     = NUM_LANES;
`else
   localparam int PAR_W     = 0;
`endif
   // Stored word: parity bits (if any) sit above the data bits.
   localparam int SW        = DATA_WIDTH + PAR_W;

   typedef enum logic {S_CLEAR = 1'b0, S_READY = 1'b1} state_t;

   function automatic logic [DATA_WIDTH-1:0] lane_merge(
      input logic [DATA_WIDTH-1:0] old_w,
      input logic [DATA_WIDTH-1:0] new_w,
      input logic [NUM_LANES-1:0]  be
   );
      logic [DATA_WIDTH-1:0] m;
      m = old_w;
      for (int k = 0; k < NUM_LANES; k++) begin
         if (be[k]) m[k*LANE_WIDTH +: LANE_WIDTH] = new_w[k*LANE_WIDTH +: LANE_WIDTH];
      end
      return m;
   endfunction

`ifdef RAM_PARITY_EN
   function automatic logic [NUM_LANES-1:0] lane_parity(input logic [DATA_WIDTH-1:0] d);
      logic [NUM_LANES-1:0] p;
      for (int k = 0; k < NUM_LANES; k++) p[k] = ^d[k*LANE_WIDTH +: LANE_WIDTH];
      return p;
   endfunction
`endif

   // ---------------- control FSM / clear engine ----------------
   state_t                r_state, w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_clr_cnt, w_clr_cnt_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
         r_clr_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_clr_cnt <= w_clr_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_clr_cnt_nxt = r_clr_cnt;
      if (r_state == S_CLEAR) begin
         w_clr_cnt_nxt = r_clr_cnt + ADDR_WIDTH'(1);
         if (&r_clr_cnt) w_state_nxt = S_READY;
      end
   end

   logic w_ready, w_clr_wr, w_wr_acc, w_rd_acc;

   assign w_ready  = !rst && (r_state == S_READY);
   assign w_clr_wr = !rst && (r_state == S_CLEAR);
   assign w_wr_acc = w_ready && write_en_i;
   assign w_rd_acc = w_ready && read_en_i;
   assign busy_o   = rst || (r_state != S_READY);

   // ---------------- storage ----------------
   logic [SW-1:0]         r_mem [DEPTH];
   logic                  w_mem_we;
   logic [ADDR_WIDTH-1:0] w_mem_waddr;
   logic [NUM_LANES-1:0]  w_mem_be;
   logic [DATA_WIDTH-1:0] w_mem_wdata;

   // Clear writes take priority; user accesses are blocked while clearing anyway.
   assign w_mem_we    = w_clr_wr || w_wr_acc;
   assign w_mem_waddr = w_clr_wr ? r_clr_cnt  : write_addr_i;
   assign w_mem_be    = w_clr_wr ? '1         : write_be_i;
   assign w_mem_wdata = w_clr_wr ? INIT_VALUE : write_data_i;

`ifdef RAM_PARITY_EN
   logic [NUM_LANES-1:0] w_mem_wpar;
   assign w_mem_wpar = lane_parity(w_mem_wdata);
`endif

   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         for (int k = 0; k < NUM_LANES; k++) begin
            if (w_mem_be[k]) begin
               r_mem[w_mem_waddr][k*LANE_WIDTH +: LANE_WIDTH] <= w_mem_wdata[k*LANE_WIDTH +: LANE_WIDTH];
`ifdef RAM_PARITY_EN
               r_mem[w_mem_waddr][DATA_WIDTH+k] <= w_mem_wpar[k];
`endif
            end
         end
      end
   end

   // ---------------- read port: array lookup + optional bypass ----------------
   logic [SW-1:0]         w_rd_old, w_rd_word;
   logic [DATA_WIDTH-1:0] w_byp_data;

   assign w_rd_old   = r_mem[read_addr_i];
   assign w_byp_data = lane_merge(w_rd_old[DATA_WIDTH-1:0], write_data_i, write_be_i);

   // In bypass mode a same-address write in the same cycle is folded into
   // the returned word. Otherwise the array value before the edge is returned.
   always_comb begin
      w_rd_word = w_rd_old;
      if ((RDW_MODE != 0) && w_wr_acc && (write_addr_i == read_addr_i)) begin
         w_rd_word[DATA_WIDTH-1:0] = w_byp_data;
`ifdef RAM_PARITY_EN
         w_rd_word[SW-1:DATA_WIDTH] = lane_parity(w_byp_data);
`endif
      end
   end

   // ---------------- pipeline stages _p0.._p(N-2) ----------------
   logic          w_last_vld;
   logic [SW-1:0] w_last_word;

   generate
      if (READ_LATENCY == 1) begin : g_lat1
         assign w_last_vld  = w_rd_acc;
         assign w_last_word = w_rd_word;
      end else begin : g_latn
         logic [SW-1:0]           r_data_p [READ_LATENCY-1];
         logic [READ_LATENCY-2:0] r_vld_p;

         always_ff @(posedge clk) begin
            if (rst) begin
               r_vld_p <= '0;
            end else begin
               r_vld_p[0] <= w_rd_acc;
               for (int i = 1; i < READ_LATENCY-1; i++) r_vld_p[i] <= r_vld_p[i-1];
            end
         end

         always_ff @(posedge clk) begin
            r_data_p[0] <= w_rd_word;
            for (int i = 1; i < READ_LATENCY-1; i++) r_data_p[i] <= r_data_p[i-1];
         end

         assign w_last_vld  = r_vld_p[READ_LATENCY-2];
         assign w_last_word = r_data_p[READ_LATENCY-2];
      end
   endgenerate

   // ---------------- output register ----------------
   logic [DATA_WIDTH-1:0] r_rd_data;
   logic                  r_rd_vld;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_vld  <= 1'b0;
         r_rd_data <= '0;
      end else begin
         r_rd_vld <= w_last_vld;
         if (w_last_vld) r_rd_data <= w_last_word[DATA_WIDTH-1:0];
      end
   end

   assign read_data_o  = r_rd_data;
   assign read_valid_o = r_rd_vld;

`ifdef RAM_PARITY_EN
   logic r_perr;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_perr <= 1'b0;
      end else if (w_last_vld) begin
         r_perr <= |(lane_parity(w_last_word[DATA_WIDTH-1:0]) ^ w_last_word[SW-1:DATA_WIDTH]);
      end
   end

   assign read_parity_err_o = r_perr;
`else
   assign read_parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_ram_block.sv
module tb_pipelined_ram_block;

   localparam int          DW    = 32;
   localparam int          AW    = 5;
   localparam int          LW    = 8;
   localparam int          NL    = DW / LW;
   localparam int          DEPTH = 2 ** AW;
   localparam int          RL0   = 3;
   localparam int          RL1   = 1;
   localparam logic [DW-1:0] INIT = 32'hA5A5A5A5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          we = 1'b0, re = 1'b0;
   logic [AW-1:0] wa = '0, ra = '0;
   logic [NL-1:0] be = '0;
   logic [DW-1:0] wd = '0;

   logic          busy0, vld0, perr0, busy1, vld1, perr1;
   logic [DW-1:0] dat0, dat1;

   always #5 clk = ~clk;

   // dut0: old-data policy, latency 3. dut1: bypass policy, latency 1.
   pipelined_ram_block #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LANE_WIDTH(LW), .READ_LATENCY(RL0),
      .RDW_MODE(0), .CLEAR_ON_RESET(1), .INIT_VALUE(INIT)) dut0 (
      .clk(clk), .rst(rst), .busy_o(busy0),
      .write_en_i(we), .write_addr_i(wa), .write_be_i(be), .write_data_i(wd),
      .read_en_i(re), .read_addr_i(ra),
      .read_data_o(dat0), .read_valid_o(vld0), .read_parity_err_o(perr0));

   pipelined_ram_block #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LANE_WIDTH(LW), .READ_LATENCY(RL1),
      .RDW_MODE(1), .CLEAR_ON_RESET(1), .INIT_VALUE(INIT)) dut1 (
      .clk(clk), .rst(rst), .busy_o(busy1),
      .write_en_i(we), .write_addr_i(wa), .write_be_i(be), .write_data_i(wd),
      .read_en_i(re), .read_addr_i(ra),
      .read_data_o(dat1), .read_valid_o(vld1), .read_parity_err_o(perr1));

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct { int due; logic [DW-1:0] data; logic perr; } rd_t;
   typedef struct { int c; logic [DW-1:0] d; logic p; } obs_t;

   logic [DW-1:0] m_mem [DEPTH];
   bit            m_bad [DEPTH];
   rd_t           q0[$], q1[$];
   obs_t          obs0[$], obs1[$];
   int            cyc = 0;
   int            clr_left = 0;
   bit            m_started = 0;
   logic [DW-1:0] e_dat0 = '0, e_dat1 = '0;
   bit            e_vld0 = 0, e_vld1 = 0, e_perr0 = 0, e_perr1 = 0;
   logic [DW-1:0] m_old, m_mrg;
   bit            m_byp;

   function automatic logic [DW-1:0] m_merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                             input logic [NL-1:0] b);
      logic [DW-1:0] mk;
      mk = '0;
      for (int k = 0; k < NL; k++) if (b[k]) mk = mk | (DW'({LW{1'b1}}) << (k*LW));
      return (o & ~mk) | (n & mk);
   endfunction

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         clr_left = DEPTH;
         q0.delete();
         q1.delete();
         e_dat0 = '0; e_dat1 = '0;
         e_vld0 = 0;  e_vld1 = 0;
         m_started = 1;
      end else begin
         if (clr_left > 0) begin
            m_mem[DEPTH-clr_left] = INIT;
            m_bad[DEPTH-clr_left] = 0;
            clr_left--;
         end else begin
            if (re) begin
               m_old = m_mem[ra];
               m_mrg = m_merge(m_old, wd, be);
               m_byp = we && (wa == ra);
               q0.push_back('{cyc + RL0 - 1, m_old, m_bad[ra]});
               q1.push_back('{cyc + RL1 - 1, m_byp ? m_mrg : m_old, m_byp ? 1'b0 : m_bad[ra]});
            end
            if (we) begin
               m_mem[wa] = m_merge(m_mem[wa], wd, be);
               if (be[0]) m_bad[wa] = 0;
            end
         end
         e_vld0 = 0;
         if (q0.size() > 0 && q0[0].due == cyc) begin
            e_vld0 = 1; e_dat0 = q0[0].data; e_perr0 = q0[0].perr; void'(q0.pop_front());
         end
         e_vld1 = 0;
         if (q1.size() > 0 && q1[0].due == cyc) begin
            e_vld1 = 1; e_dat1 = q1[0].data; e_perr1 = q1[0].perr; void'(q1.pop_front());
         end
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (m_started) begin
         check("busy0", busy0, rst || (clr_left > 0));
         check("busy1", busy1, rst || (clr_left > 0));
         check("valid0", vld0, e_vld0);
         check("valid1", vld1, e_vld1);
         check("data0", dat0, e_dat0);
         check("data1", dat1, e_dat1);
         if (e_vld0) check("perr0", perr0, e_perr0);
         if (e_vld1) check("perr1", perr1, e_perr1);
         if (vld0) obs0.push_back('{cyc, dat0, perr0});
         if (vld1) obs1.push_back('{cyc, dat1, perr1});
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive(input logic w, input logic [AW-1:0] a_w, input logic [NL-1:0] b,
                        input logic [DW-1:0] d, input logic r, input logic [AW-1:0] a_r);
      we = w; wa = a_w; be = b; wd = d; re = r; ra = a_r;
      @(posedge clk); #1;
      we = 0; re = 0; be = '0;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NL-1:0] b);
      drive(1'b1, a, b, d, 1'b0, '0);
   endtask

   task automatic rd(input logic [AW-1:0] a);
      drive(1'b0, '0, '0, '0, 1'b1, a);
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic do_reset(input int n);
      rst = 1;
      repeat (n) @(posedge clk);
      #1 rst = 0;
   endtask

   task automatic count_busy(output int n);
      n = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (busy0) n++;
         else break;
      end
   endtask

   task automatic clear_obs();
      obs0.delete();
      obs1.delete();
   endtask

   int nb, acc;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
      $fatal(1, "watchdog");
   end

   initial begin
      // Clear after a 2-cycle reset, then every location reads INIT.
      do_reset(2);
      count_busy(nb);
      check("clear_busy_len", nb, 32);
      clear_obs();
      for (int a = 0; a < DEPTH; a++) rd(AW'(a));
      idle(5);
      check("clear_rd_cnt0", obs0.size(), 32);
      check("clear_rd_cnt1", obs1.size(), 32);
      for (int i = 0; i < obs0.size() && i < 32; i++) check("clear_rd_val", obs0[i].d, 32'hA5A5A5A5);

      // Latency / throughput.
      for (int i = 0; i < 8; i++) wr(AW'(i), 32'h10 + i, 4'hF);
      clear_obs();
      rd(0);
      acc = cyc;
      for (int i = 1; i < 8; i++) rd(AW'(i));
      idle(5);
      check("lat_cnt0", obs0.size(), 8);
      if (obs0.size() > 0) check("lat_first0", obs0[0].c - acc, 2);
      if (obs1.size() > 0) check("lat_first1", obs1[0].c - acc, 0);
      for (int i = 0; i < obs0.size() && i < 8; i++) begin
         check("lat_b2b", obs0[i].c - obs0[0].c, i);
         check("lat_data", obs0[i].d, 32'h10 + i);
      end

      // Byte enables, including an all-zero enable no-op.
      wr(4, 32'h11223344, 4'hF);
      wr(4, 32'hAABBCCDD, 4'b0101);
      wr(4, 32'hFFFFFFFF, 4'b0000);
      clear_obs();
      rd(4);
      idle(4);
      check("be_cnt", obs0.size(), 1);
      if (obs0.size() > 0) check("be_data0", obs0[0].d, 32'h11BB33DD);
      if (obs1.size() > 0) check("be_data1", obs1[0].d, 32'h11BB33DD);

      // Read-during-write: same address full/partial, then different address.
      wr(9, 32'h01, 4'hF);
      wr(10, 32'h11223344, 4'hF);
      clear_obs();
      drive(1'b1, 9, 4'hF, 32'h02, 1'b1, 9);
      drive(1'b1, 10, 4'b1010, 32'hAABBCCDD, 1'b1, 10);
      drive(1'b1, 11, 4'hF, 32'h33, 1'b1, 9);
      idle(4);
      check("rdw_cnt0", obs0.size(), 3);
      check("rdw_cnt1", obs1.size(), 3);
      if (obs0.size() == 3) begin
         check("rdw_old_full", obs0[0].d, 32'h01);
         check("rdw_old_part", obs0[1].d, 32'h11223344);
         check("rdw_old_diff", obs0[2].d, 32'h02);
      end
      if (obs1.size() == 3) begin
         check("rdw_new_full", obs1[0].d, 32'h02);
         check("rdw_new_part", obs1[1].d, 32'hAA22CC44);
         check("rdw_new_diff", obs1[2].d, 32'h02);
      end

      // Write behind an in-flight read does not alter it.
      wr(12, 32'h55, 4'hF);
      clear_obs();
      rd(12);
      wr(12, 32'h66, 4'hF);
      idle(4);
      if (obs0.size() > 0) check("inflight_old", obs0[0].d, 32'h55);

      // Reset discards in-flight reads and restarts the clear.
      clear_obs();
      rd(0);
      rd(1);
      do_reset(1);
      count_busy(nb);
      check("rst_flight_cnt0", obs0.size(), 0);
      check("rst_flight_cnt1", obs1.size(), 2);
      check("rst_flight_busy", nb, 32);

      // Accesses during clear cycle 10 are ignored.
      do_reset(1);
      idle(10);
      clear_obs();
      drive(1'b1, 5, 4'hF, 32'hDEADBEEF, 1'b1, 5);
      count_busy(nb);
      check("busy_remaining", nb, 21);
      idle(2);
      check("busy_no_valid", obs0.size() + obs1.size(), 0);
      rd(5);
      idle(4);
      if (obs0.size() > 0) check("busy_no_corrupt", obs0[0].d, 32'hA5A5A5A5);

      // Reset at clear cycle 20 restarts the full clear.
      do_reset(1);
      idle(20);
      do_reset(1);
      count_busy(nb);
      check("midclear_busy", nb, 32);

`ifdef RAM_PARITY_EN
      wr(3, 32'h12345678, 4'hF);
      dut0.r_mem[3][0] = ~dut0.r_mem[3][0];
      dut1.r_mem[3][0] = ~dut1.r_mem[3][0];
      m_mem[3][0] = ~m_mem[3][0];
      m_bad[3] = 1;
      clear_obs();
      rd(3);
      rd(2);
      idle(4);
      if (obs0.size() == 2) begin
         check("par_err_bad", obs0[0].p, 1'b1);
         check("par_err_clean", obs0[1].p, 1'b0);
      end
`endif

      idle(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pipelined_ram_block.md
Name: pipelined_ram_block

Overview:
- Parametrised single-clock simple-dual-port RAM. It is the next generation of the core's sample/coefficient storage.
- Adds configurable read latency, a read-valid handshake, per-lane byte enables, a selectable read-during-write policy and a post-reset memory clear engine.
- Sits between the input sample loader (write side) and the convolution datapath (read side).

Parameters:
- DATA_WIDTH, 8, word width in bits; must be a multiple of LANE_WIDTH.
- ADDR_WIDTH, 5, address bits; depth = 2**ADDR_WIDTH.
- LANE_WIDTH, 8, bits per byte-enable lane; NUM_LANES = DATA_WIDTH/LANE_WIDTH.
- READ_LATENCY, 1, cycles from accepted read to rd_valid_o; legal range 1..4.
- RDW_MODE, 0, same-address read/write in the same cycle: 0 = old data, 1 = new data (bypass).
- CLEAR_ON_RESET, 1, 1 = clear every location after reset; 0 = no clear.
- INIT_VALUE, 0, word written to every location during clear.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; synchronous, active-high.
- busy_o  output  1  high while clearing; accesses are ignored.
- write_en_i  input  1  write strobe.
- write_addr_i  input  ADDR_WIDTH  write address.
- write_be_i  input  NUM_LANES  lane enables; bit k enables bits [k*LANE_WIDTH +: LANE_WIDTH].
- write_data_i  input  DATA_WIDTH  write data.
- read_en_i  input  1  read request.
- read_addr_i  input  ADDR_WIDTH  read address.
- read_data_o  output  DATA_WIDTH  read data; registered.
- read_valid_o  output  1  one-cycle pulse, qualifies read_data_o.
- read_parity_err_o  output  1  parity error flag, qualified by read_valid_o (see Optional Feature).

Behaviour:
- Reset (rst=1 at a clk edge):
  - read_valid_o=0, read_data_o=0, read_parity_err_o=0.
  - All read-pipeline valid stages cleared.
  - Clear counter = 0; FSM -> CLEAR if CLEAR_ON_RESET=1, else READY.
  - busy_o=1 while rst is high.
  - RAM contents are not reset by rst itself.
- FSM CLEAR:
  - Each cycle writes INIT_VALUE to address clear_cnt (all lanes), then clear_cnt++.
  - After writing address 2**ADDR_WIDTH-1 -> READY.
  - busy_o=1 for exactly 2**ADDR_WIDTH cycles after rst deasserts.
- FSM READY: busy_o=0. READY is only left via rst.
- rst asserted mid-clear: counter restarts at 0, and the full clear is repeated.
- CLEAR_ON_RESET=0: busy_o falls in the first cycle with rst=0.
- Accesses while busy_o=1 or rst=1: write_en_i and read_en_i are ignored; not queued, no read_valid_o generated.
- Write:
  - While READY and write_en_i=1, lane k of mem[write_addr_i] is updated at the clk edge iff write_be_i[k]=1.
  - write_be_i=0 is a no-op.
- Read:
  - Request accepted when READY and read_en_i=1.
  - read_data_o/read_valid_o appear exactly READ_LATENCY cycles after the accepting edge.
  - Fully pipelined: one read per cycle, back-to-back, no bubbles.
  - read_data_o holds its last value when read_valid_o=0.
- Read-during-write, same address, same cycle:
  - RDW_MODE=0: returns the pre-write word.
  - RDW_MODE=1: returns the merged word (written lanes new, unwritten lanes old).
  - Different addresses: independent.
- Write to an address with a read to it still in flight: the read returns the data as of its accepting edge; later writes do not alter it.
- Address wrap: none. Addresses are ADDR_WIDTH wide, so all values are legal.
- Reset during in-flight reads: the in-flight reads are discarded; no read_valid_o after the reset edge.

Optional Feature:
- Macro: RAM_PARITY_EN.
- Defined:
  - One extra even-parity bit per lane is stored.
  - Computed on every write, including clear writes.
  - Checked on read data at output.
  - read_parity_err_o=1 with read_valid_o if any lane mismatches.
  - With RDW_MODE=1 bypass, parity is computed on the merged word.
- Undefined: no parity storage; read_parity_err_o tied 0.

Test Plan:
- Clear: rst high 2 cycles with CLEAR_ON_RESET=1, ADDR_WIDTH=5, INIT_VALUE=8'hA5 -> busy_o high 32 cycles; then reading all 32 addresses returns 8'hA5.
- Latency/throughput: READ_LATENCY=3; write addr 0..7 = 8'h10..8'h17; read 0..7 back-to-back -> read_valid_o high 8 consecutive cycles starting 3 cycles after the first request; data 8'h10..8'h17 in order.
- Byte enables: DATA_WIDTH=32, mem[4]=32'h11223344; write 32'hAABBCCDD with be=4'b0101 -> read 32'h11BB33DD.
- RDW: mem[9]=8'h01; same-cycle write 8'h02 and read addr 9 -> RDW_MODE=0 returns 8'h01; RDW_MODE=1 returns 8'h02.
- Busy and mid-clear reset:
  - Issue write/read at clear cycle 10 -> no read_valid_o; location not corrupted after clear.
  - Assert rst at clear cycle 20 -> busy_o lasts 32 cycles from the new rst release.
- Parity (RAM_PARITY_EN): force-flip one stored data bit at addr 3 -> read of addr 3 gives read_parity_err_o=1 with read_valid_o; clean addresses give 0.
